subtract_divider: RTL and testbench

- Sequential unsigned integer divider built on repeated trial subtraction, the inverse of the 16-bit ADDER datapath.
- Sits beside the ALU in the emulator core and serves DIV/MOD instructions.
- Processes one quotient bit per clock and uses a start/busy/done handshake so the control unit can stall while it runs.

---
 rtl/subtract_divider_pkg.sv | 17 +
 rtl/subtract_divider_if.sv | 29 ++
 rtl/subtract_divider_sub_stage.sv | 18 +
 rtl/subtract_divider.sv | 115 +++++++++++
 tb/tb_subtract_divider.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/subtract_divider_pkg.sv
// rtl/subtract_divider_pkg.sv - shared width default and FSM encodings for subtract_divider
package subtract_divider_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/subtract_divider_if.sv
// rtl/subtract_divider_if.sv - start/busy/done request bus between control unit and divider
interface subtract_divider_if
  import subtract_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Control unit side: issues requests, watches the handshake and results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/subtract_divider_sub_stage.sv
// rtl/subtract_divider_sub_stage.sv - combinational trial subtractor with borrow out
module sub_stage
  import subtract_divider_pkg::*;
#(
  parameter int N = WIDTH_DEFAULT + 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_out_o
);

  // Extend by one bit so the wrap-around of a - b lands in the borrow.
  always_comb begin
    {borrow_out_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
  end

endmodule

// File: rtl/subtract_divider.sv
// rtl/subtract_divider.sv - unsigned restoring divider, one quotient bit per clock
module subtract_divider
  import subtract_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  subtract_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shift register
  logic [WIDTH-1:0] dsr_q, dsr_d;       // latched divisor
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;       // quotient being assembled
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;

  // The partial remainder is always below the divisor, so its top bit is
  // zero and dropping it in the shift loses nothing.
  assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_stage #(.N(WIDTH + 1)) u_sub_stage (
    .a_i          (shifted),
    .b_i          ({1'b0, dsr_q}),
    .diff_o       (trial_diff),
    .borrow_out_o (trial_borrow)
  );

  // Next-state and datapath update; a new request is accepted outside RUN only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_RUN: begin
        rem_d = trial_borrow ? shifted : trial_diff;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          quo_out_d = quo_d;
          rem_out_d = rem_d[WIDTH-1:0];
        end
      end
      default: begin
        // IDLE, DONE and any unreachable encoding fall back to IDLE.
        state_d = S_IDLE;
        if (bus.start) begin
          dbz_d = (bus.divisor == '0);
          if (bus.divisor == '0) begin
            state_d   = S_DONE;
            quo_out_d = '1;
            rem_out_d = bus.dividend;
          end else begin
            state_d = S_RUN;
            dvd_d   = bus.dividend;
            dsr_d   = bus.divisor;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
    endcase
  end

  // State registers; reset aborts any operation in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_subtract_divider.sv
// tb/tb_subtract_divider.sv - table and scoreboard bench for subtract_divider and sub_stage
module tb_subtract_divider;

  logic clk;
  logic reset;

  subtract_divider_if #(.WIDTH(16)) bus ();

  subtract_divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0] ss_a, ss_b, ss_diff;
  logic        ss_borrow;

  sub_stage #(.N(17)) u_ss (
    .a_i          (ss_a),
    .b_i          (ss_b),
    .diff_o       (ss_diff),
    .borrow_out_o (ss_borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] d;
    logic        bo;
  } ss_vec_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int   cycles      = 0;
    int   busy_cycles = 0;
    bit   got         = 1'b0;
    exp_t e;
    while (!got && cycles < 40) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'($urandom);
      cycles++;
      if (bus.busy) busy_cycles++;
      if (bus.done) got = 1'b1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
        check({name, "_quotient"}, 32'(bus.quotient), 32'(e.q));
        check({name, "_remainder"}, 32'(bus.remainder), 32'(e.r));
        check({name, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(e.z));
      end
    end
  endtask

  initial begin
    vec_t    vecs[11];
    ss_vec_t ss_vecs[5];
    int      spurious;

    vecs[0]  = '{16'd2649,  16'd113,   16'd23,    16'd50,    1'b0};
    vecs[1]  = '{16'd5,     16'd9,     16'd0,     16'd5,     1'b0};
    vecs[2]  = '{16'd12345, 16'd1,     16'd12345, 16'd0,     1'b0};
    vecs[3]  = '{16'd40000, 16'd3,     16'd13333, 16'd1,     1'b0};
    vecs[4]  = '{16'd1,     16'd65535, 16'd0,     16'd1,     1'b0};
    vecs[5]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
    vecs[6]  = '{16'd65534, 16'd65535, 16'd0,     16'd65534, 1'b0};
    vecs[7]  = '{16'd32768, 16'd2,     16'd16384, 16'd0,     1'b0};
    vecs[8]  = '{16'd60000, 16'd256,   16'd234,   16'd96,    1'b0};
    vecs[9]  = '{16'd0,     16'd0,     16'd65535, 16'd0,     1'b1};
    vecs[10] = '{16'd1000,  16'd7,     16'd142,   16'd6,     1'b0};

    ss_vecs[0] = '{17'd5,       17'd3,       17'd2,       1'b0};
    ss_vecs[1] = '{17'd3,       17'd5,       17'h1FFFE,   1'b1};
    ss_vecs[2] = '{17'd0,       17'd0,       17'd0,       1'b0};
    ss_vecs[3] = '{17'h10000,   17'h0FFFF,   17'd1,       1'b0};
    ss_vecs[4] = '{17'h0FFFF,   17'h10000,   17'h1FFFF,   1'b1};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    ss_a  = '0;
    ss_b  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Trial subtractor on its own.
    for (int i = 0; i < 5; i++) begin
      ss_a = ss_vecs[i].a;
      ss_b = ss_vecs[i].b;
      #1;
      check($sformatf("sub_stage_diff_%0d", i), 32'(ss_diff), 32'(ss_vecs[i].d));
      check($sformatf("sub_stage_borrow_%0d", i), 32'(ss_borrow), 32'(ss_vecs[i].bo));
    end

    // Table: each operation from IDLE, then confirm done is a single pulse.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
      wait_done($sformatf("vec%0d", i), vecs[i].z ? 1 : 17, vecs[i].z ? 0 : 16);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d_hold_q", i), 32'(bus.quotient), 32'(vecs[i].q));
    end

    // Back-to-back: new start held during the DONE cycle, no idle cycle between.
    @(negedge clk);
    issue(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
    wait_done("b2b_first", 17, 16);
    issue(16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0);
    wait_done("b2b_second", 17, 16);

    // Divide by zero followed by a normal op; flag clears on acceptance.
    @(negedge clk);
    @(negedge clk);
    issue(16'd7, 16'd0, 16'd65535, 16'd7, 1'b1);
    wait_done("dbz", 1, 0);
    @(negedge clk);
    issue(16'd10, 16'd3, 16'd3, 16'd1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("dbz_clear_on_start", 32'(bus.div_by_zero), 32'd0);
    check("dbz_next_busy", 32'(bus.busy), 32'd1);
    check("dbz_q_held_in_run", 32'(bus.quotient), 32'd65535);
    wait_done("after_dbz", 16, 15);

    // Start during RUN is ignored.
    @(negedge clk);
    issue(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd9;
    bus.divisor  = 16'd3;
    wait_done("ignored_start", 12, 11);
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) spurious++;
    end
    check("ignored_start_no_extra_done", 32'(spurious), 32'd0);

    // Reset in the middle of RUN aborts immediately.
    @(negedge clk);
    issue(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(16'd12, 16'd4, 16'd3, 16'd0, 1'b0);
    wait_done("after_reset", 17, 16);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
